id_regfile_pipe: RTL
====================

ID_REGFILE_PIPE -- requirements
Module: id_regfile_pipe

Interface
REQ-001 Parameter XLEN, default 32: datapath width of PC, instruction and register data.
REQ-002 Parameter NREGS, default 32: register count (power of two, 2..32); index width AW = $clog2(NREGS).
REQ-003 Parameter RESET_INIT, default 1: 1 = register i resets to i; 0 = all registers reset to 0.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  IF stage presents pc_in/inst_in.
REQ-007 in_ready  out  1  stage accepts the IF beat this cycle.
REQ-008 pc_in  in  XLEN  PC of incoming instruction.
REQ-009 inst_in  in  32  incoming instruction word.
REQ-010 wb_en  in  1  writeback write enable.
REQ-011 wb_rd  in  AW  writeback destination index.
REQ-012 wb_data  in  XLEN  writeback data.
REQ-013 flush  in  1  discard the held ID/EX beat and any beat accepted this cycle.
REQ-014 ex_ready  in  1  EX consumes the output beat.
REQ-015 ex_valid  out  1  output beat valid.
REQ-016 pc_ex, inst_ex  out  XLEN, 32  registered copies of the accepted PC and instruction.
REQ-017 rs1_ex, rs2_ex  out  XLEN  registered operand values.
REQ-018 rs1_idx_ex, rs2_idx_ex, rd_ex  out  AW each  registered indices inst[19:15], inst[24:20], inst[11:7], truncated to AW.
REQ-019 funct3_ex  out  3  registered inst[14:12].

Function
REQ-020 in_ready SHALL equal !ex_valid || ex_ready (combinational, no flush dependency).
REQ-021 Accept = in_valid && in_ready; on accept all *_ex registers load next edge and ex_valid becomes 1.
REQ-022 ex_valid && ex_ready without accept SHALL clear ex_valid next edge; ex_valid && !ex_ready SHALL hold every *_ex register.
REQ-023 flush SHALL force ex_valid to 0 next edge, overriding accept; in_ready is unaffected.
REQ-024 Register 0 SHALL always read 0; wb_en with wb_rd == 0 SHALL be ignored.
REQ-025 wb_en with wb_rd != 0 SHALL write register wb_rd on the edge, regardless of handshake state.
REQ-026 Read bypass: operand read with index == wb_rd, wb_en=1, index != 0 SHALL return wb_data in the same cycle.
REQ-027 Hold refresh: while ex_valid && !ex_ready, wb write with wb_rd == rs1_idx_ex (nonzero) SHALL update rs1_ex next edge; same for rs2.
REQ-028 Capture latency 1 cycle: inst accepted at edge N appears on *_ex after edge N.
REQ-029 Indices SHALL use the low AW bits of the instruction fields; no out-of-range access.

Reset
REQ-030 reset SHALL clear ex_valid, pc_ex, inst_ex, rs1_ex, rs2_ex, all index outputs and funct3_ex to 0 on the next edge.
REQ-031 reset SHALL initialise registers per RESET_INIT (register 0 always 0) and override simultaneous wb_en writes.
REQ-032 reset mid-hold SHALL drop the held beat; in_ready is 1 the cycle after reset deasserts.

Structure
REQ-033 Package id_pkg SHALL hold instruction field bit positions (RS1/RS2/RD/FUNCT3 lsb/msb) and default XLEN/NREGS constants.
REQ-034 Register file SHALL be sub-module id_regfile (2 async read ports, 1 sync write port, bypass, x0 rule, reset init); pipeline register and handshake live in the top.

Verification
REQ-035 Reset, RESET_INIT=1, then inst 0x00A08033 (rs1=1, rs2=10, rd=0) accepted -> next cycle ex_valid=1, rs1_ex=1, rs2_ex=10, rd_ex=0.
REQ-036 wb_en=1, wb_rd=5, wb_data=0xDEADBEEF same cycle as accepted inst with rs1=5 -> rs1_ex=0xDEADBEEF.
REQ-037 wb_en=1, wb_rd=0, wb_data=0x1234 then read rs1=0 -> rs1_ex=0.
REQ-038 ex_ready=0 for 3 cycles with beat held, wb write rd=rs2_idx_ex=7 data 0x55 -> rs2_ex=0x55, pc_ex unchanged, in_ready=0 throughout.
REQ-039 flush asserted with in_valid=1, in_ready=1 -> ex_valid=0 next cycle; following beat accepted normally.
REQ-040 reset asserted while ex_valid=1, ex_ready=0 -> all outputs 0 next cycle, register 3 reads 3.

Source files
------------

// File: rtl/id_pkg.sv
// Shared constants for the decode/register-read stage: instruction field
// positions, default widths and a field-extraction helper.
package id_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int INST_W    = 32;
  localparam int FIELD_W   = 5;

  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;

  typedef struct packed {
    logic [FIELD_W-1:0] rs1;
    logic [FIELD_W-1:0] rs2;
    logic [FIELD_W-1:0] rd;
    logic [2:0]         funct3;
  } inst_fields_t;

  function automatic inst_fields_t decode_fields(input logic [INST_W-1:0] inst);
    inst_fields_t f;
    f.rs1    = inst[RS1_MSB:RS1_LSB];
    f.rs2    = inst[RS2_MSB:RS2_LSB];
    f.rd     = inst[RD_MSB:RD_LSB];
    f.funct3 = inst[FUNCT3_MSB:FUNCT3_LSB];
    return f;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two asynchronous read ports with same-cycle
// writeback bypass, one synchronous write port, hard-wired zero register.
module id_regfile
  import id_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int NREGS      = DEF_NREGS,
  parameter int RESET_INIT = 1,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_idx,
  input  logic [AW-1:0]   rs2_idx,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wb_live;

  // A write to index 0 is architecturally a no-op, so it never qualifies.
  assign wb_live = wb_en && (wb_rd != '0);

  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   idx,
    input logic            wr_live,
    input logic [AW-1:0]   wr_idx,
    input logic [XLEN-1:0] wr_data,
    input logic [XLEN-1:0] stored
  );
    if (idx == '0)
      return '0;
    else if (wr_live && (wr_idx == idx))
      return wr_data;
    else
      return stored;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= ((RESET_INIT != 0) && (i != 0)) ? XLEN'(i) : '0;
    end else if (wb_live) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = read_port(rs1_idx, wb_live, wb_rd, wb_data, regs[rs1_idx]);
    rs2_data = read_port(rs2_idx, wb_live, wb_rd, wb_data, regs[rs2_idx]);
  end

endmodule

// File: rtl/id_regfile_pipe.sv
// Decode stage: reads operands for the incoming instruction and holds them in
// a single ID/EX register slice with valid/ready handshake and flush.
module id_regfile_pipe
  import id_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int NREGS      = DEF_NREGS,
  parameter int RESET_INIT = 1,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     inst_in,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] pc_ex,
  output logic [31:0]     inst_ex,
  output logic [XLEN-1:0] rs1_ex,
  output logic [XLEN-1:0] rs2_ex,
  output logic [AW-1:0]   rs1_idx_ex,
  output logic [AW-1:0]   rs2_idx_ex,
  output logic [AW-1:0]   rd_ex,
  output logic [2:0]      funct3_ex
);

  inst_fields_t    fields_p0;
  logic [AW-1:0]   rs1_idx_p0;
  logic [AW-1:0]   rs2_idx_p0;
  logic [AW-1:0]   rd_idx_p0;
  logic [XLEN-1:0] rs1_val_p0;
  logic [XLEN-1:0] rs2_val_p0;
  logic            accept;
  logic            hold;

  function automatic logic wb_hits(
    input logic          en,
    input logic [AW-1:0] wr_idx,
    input logic [AW-1:0] held_idx
  );
    return en && (wr_idx != '0) && (wr_idx == held_idx);
  endfunction

  // ID: field decode and operand read
  assign fields_p0  = decode_fields(inst_in);
  assign rs1_idx_p0 = fields_p0.rs1[AW-1:0];
  assign rs2_idx_p0 = fields_p0.rs2[AW-1:0];
  assign rd_idx_p0  = fields_p0.rd[AW-1:0];

  id_regfile #(
    .XLEN       (XLEN),
    .NREGS      (NREGS),
    .RESET_INIT (RESET_INIT)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_idx  (rs1_idx_p0),
    .rs2_idx  (rs2_idx_p0),
    .rs1_data (rs1_val_p0),
    .rs2_data (rs2_val_p0),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  assign in_ready = !ex_valid || ex_ready;
  assign accept   = in_valid && in_ready;
  assign hold     = ex_valid && !ex_ready;

  // ID/EX boundary
  always_ff @(posedge clk) begin
    if (reset)
      ex_valid <= 1'b0;
    else if (flush)
      ex_valid <= 1'b0;
    else if (accept)
      ex_valid <= 1'b1;
    else if (ex_ready)
      ex_valid <= 1'b0;
  end

  // While stalled, a writeback to a held source keeps the operand current.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_ex      <= '0;
      inst_ex    <= '0;
      rs1_ex     <= '0;
      rs2_ex     <= '0;
      rs1_idx_ex <= '0;
      rs2_idx_ex <= '0;
      rd_ex      <= '0;
      funct3_ex  <= '0;
    end else if (accept) begin
      pc_ex      <= pc_in;
      inst_ex    <= inst_in;
      rs1_ex     <= rs1_val_p0;
      rs2_ex     <= rs2_val_p0;
      rs1_idx_ex <= rs1_idx_p0;
      rs2_idx_ex <= rs2_idx_p0;
      rd_ex      <= rd_idx_p0;
      funct3_ex  <= fields_p0.funct3;
    end else if (hold) begin
      if (wb_hits(wb_en, wb_rd, rs1_idx_ex))
        rs1_ex <= wb_data;
      if (wb_hits(wb_en, wb_rd, rs2_idx_ex))
        rs2_ex <= wb_data;
    end
  end

endmodule
